ep_buffer_ctrl: RTL

Endpoint buffer controller that shares the single-write-port/single-read-port endpoint RAM between the USB receive path (byte writer) and the transmit path (byte reader). It partitions the RAM into one fixed circular FIFO per endpoint, keeps per-endpoint pointers and fill counts, and gates each request against full/empty status. It drives the RAM ports directly and reports per-endpoint status and overrun errors to the endpoint logic.

---
 rtl/ep_buffer_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/ep_buffer_ctrl.sv
// Endpoint buffer controller: one circular FIFO per endpoint inside a shared
// single-write/single-read RAM, with full/empty gating, flush and overrun errors.
module ep_buffer_ctrl #(
   parameter int ENDPOINTS  = 4,
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic                         iWrReq,
   input  logic [$clog2(ENDPOINTS)-1:0] iWrEndp,
   input  logic [DATA_WIDTH-1:0]        iWrData,
   output logic                         oWrReady,
   input  logic                         iRdReq,
   input  logic [$clog2(ENDPOINTS)-1:0] iRdEndp,
   output logic                         oRdReady,
   output logic [DATA_WIDTH-1:0]        oRdData,
   output logic                         oRdValid,
   input  logic                         iFlush,
   input  logic [$clog2(ENDPOINTS)-1:0] iFlushEndp,
   output logic [ENDPOINTS-1:0]         oEmpty,
   output logic [ENDPOINTS-1:0]         oFull,
   output logic                         oErr,
   output logic                         oRamWriteEnable,
   output logic [ADDR_WIDTH-1:0]        oRamWriteAddress,
   output logic [DATA_WIDTH-1:0]        oRamDataIn,
   output logic [ADDR_WIDTH-1:0]        oRamReadAddress,
   input  logic [DATA_WIDTH-1:0]        iRamDataOut
);

   localparam int EP_W  = $clog2(ENDPOINTS);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]      wr_ptr [ENDPOINTS];
   logic [PTR_W-1:0]      rd_ptr [ENDPOINTS];
   logic [CNT_W-1:0]      count  [ENDPOINTS];
   logic [ADDR_WIDTH-1:0] rd_addr_q;

   logic                  flush_wr, flush_rd;
   logic                  wr_accept, rd_accept;
   logic                  wr_err, rd_err;
   logic [ENDPOINTS-1:0]  wr_sel, rd_sel, flush_sel;

   always_comb begin
      for (int e = 0; e < ENDPOINTS; e++) begin
         oEmpty[e] = (count[e] == '0);
         oFull[e]  = (count[e] == CNT_W'(DEPTH));
      end
   end

   // A flush of the addressed endpoint silently wins over a request to it:
   // the request is neither accepted nor reported as an error.
   always_comb begin
      flush_wr  = iFlush && (iFlushEndp == iWrEndp);
      flush_rd  = iFlush && (iFlushEndp == iRdEndp);
      oWrReady  = !oFull[iWrEndp]  && !flush_wr && !Reset;
      oRdReady  = !oEmpty[iRdEndp] && !flush_rd && !Reset;
      wr_accept = iWrReq && oWrReady;
      rd_accept = iRdReq && oRdReady;
      wr_err    = iWrReq && oFull[iWrEndp]  && !flush_wr;
      rd_err    = iRdReq && oEmpty[iRdEndp] && !flush_rd;
      for (int e = 0; e < ENDPOINTS; e++) begin
         wr_sel[e]    = wr_accept && (iWrEndp == EP_W'(e));
         rd_sel[e]    = rd_accept && (iRdEndp == EP_W'(e));
         flush_sel[e] = iFlush && (iFlushEndp == EP_W'(e));
      end
   end

   // RAM write port and read address are driven straight from the accept
   // decision; the RAM returns read data one cycle later.
   always_comb begin
      oRamWriteEnable  = wr_accept;
      oRamWriteAddress = ADDR_WIDTH'({iWrEndp, wr_ptr[iWrEndp]});
      oRamDataIn       = iWrData;
      oRamReadAddress  = rd_accept ? ADDR_WIDTH'({iRdEndp, rd_ptr[iRdEndp]}) : rd_addr_q;
      oRdData          = iRamDataOut;
   end

   // NOTE: the per-endpoint pointer/count arrays are small register files, so
   // they are reset like any other state; only the external RAM keeps its contents.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int e = 0; e < ENDPOINTS; e++) begin
            wr_ptr[e] <= '0;
            rd_ptr[e] <= '0;
            count[e]  <= '0;
         end
         rd_addr_q <= '0;
         oRdValid  <= 1'b0;
         oErr      <= 1'b0;
      end else begin
         for (int e = 0; e < ENDPOINTS; e++) begin
            if (flush_sel[e]) begin
               wr_ptr[e] <= '0;
               rd_ptr[e] <= '0;
               count[e]  <= '0;
            end else begin
               if (wr_sel[e]) wr_ptr[e] <= wr_ptr[e] + 1'b1;
               if (rd_sel[e]) rd_ptr[e] <= rd_ptr[e] + 1'b1;
               if (wr_sel[e] && !rd_sel[e])
                  count[e] <= count[e] + 1'b1;
               else if (rd_sel[e] && !wr_sel[e])
                  count[e] <= count[e] - 1'b1;
            end
         end
         if (rd_accept) rd_addr_q <= oRamReadAddress;
         oRdValid <= rd_accept;
         oErr     <= wr_err || rd_err;
      end
   end

endmodule
